// File: rtl/cache_port_arbiter.sv
// ---------------------------------------------------------------------------
// cache_port_arbiter
//   Arbitrates PORT_NUM cache request ports onto a single burst master port.
//   Only one transaction is in flight at a time. Once a port wins, it keeps the
//   grant from the address phase until the transaction completes: the last read
//   beat for reads, or the write response for writes.
//
//   Arbitration (PRIO_MODE):
//     0 : round-robin. The search starts at (last_served+1) and wraps around.
//     1 : fixed priority. The lowest index wins.
//
// Ports
//   clk, rst_n       : clock; asynchronous active-low reset
//   req_*            : per-port request channel (valid/ready, addr, write, len)
//   wdata_i/wvalid_i/wready_o : per-port write data channel
//   rdata_o/rvalid_o/rlast_o  : read data returned to the granted port
//   wdone_o          : one-cycle write completion pulse to the granted port
//   m_req_* / m_addr_o / m_write_o / m_len_o : master address channel
//   m_wdata_o/m_wvalid_o/m_wready_i/m_wlast_o : master write data channel
//   m_rdata_i/m_rvalid_i/m_rlast_i           : master read data channel
//   m_bvalid_i       : master write response
//   fsm_state        : current FSM state (debug observation)
//
// Handshake rule on every channel: a beat transfers on the rising edge where
// valid and ready are both high. A valid signal never depends on the ready
// signal of the same channel. Request fields must stay stable while valid is
// high, because the address is not latched here.
// ---------------------------------------------------------------------------
module cache_port_arbiter #(
    parameter int PORT_NUM  = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int LEN_W     = 8,
    parameter int PRIO_MODE = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [PORT_NUM-1:0]        req_valid_i,
    output logic [PORT_NUM-1:0]        req_ready_o,
    input  logic [PORT_NUM*ADDR_W-1:0] req_addr_i,
    input  logic [PORT_NUM-1:0]        req_write_i,
    input  logic [PORT_NUM*LEN_W-1:0]  req_len_i,
    input  logic [PORT_NUM*DATA_W-1:0] wdata_i,
    input  logic [PORT_NUM-1:0]        wvalid_i,
    output logic [PORT_NUM-1:0]        wready_o,
    output logic [DATA_W-1:0]          rdata_o,
    output logic [PORT_NUM-1:0]        rvalid_o,
    output logic                       rlast_o,
    output logic [PORT_NUM-1:0]        wdone_o,
    output logic                       m_req_valid_o,
    input  logic                       m_req_ready_i,
    output logic [ADDR_W-1:0]          m_addr_o,
    output logic                       m_write_o,
    output logic [LEN_W-1:0]           m_len_o,
    output logic [DATA_W-1:0]          m_wdata_o,
    output logic                       m_wvalid_o,
    input  logic                       m_wready_i,
    output logic                       m_wlast_o,
    input  logic [DATA_W-1:0]          m_rdata_i,
    input  logic                       m_rvalid_i,
    input  logic                       m_rlast_i,
    input  logic                       m_bvalid_i,
    output logic [2:0]                 fsm_state
);

    localparam int GW = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_WDATA = 3'd2,
        ST_RDATA = 3'd3,
        ST_WRESP = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [GW-1:0]         grant_q, grant_d;
    logic [GW-1:0]         last_q, last_d;
    logic [LEN_W-1:0]      cnt_q, cnt_d;
    logic [PORT_NUM-1:0]   wdone_q, wdone_d;
    logic [GW-1:0]         winner;
    logic                  found;
    int                    idx;

    // Fields of the currently granted port.
    logic [ADDR_W-1:0]     g_addr;
    logic [LEN_W-1:0]      g_len;
    logic [DATA_W-1:0]     g_wdata;
    logic                  g_write;
    logic                  g_wvalid;

    assign g_addr   = req_addr_i[int'(grant_q)*ADDR_W +: ADDR_W];
    assign g_len    = req_len_i[int'(grant_q)*LEN_W +: LEN_W];
    assign g_wdata  = wdata_i[int'(grant_q)*DATA_W +: DATA_W];
    assign g_write  = req_write_i[grant_q];
    assign g_wvalid = wvalid_i[grant_q];

    // Winner selection. Round-robin visits last_served+1, +2, ... with wrap,
    // so the port served last is checked last.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int i = 0; i < PORT_NUM; i++) begin
            if (PRIO_MODE == 1) idx = i;
            else                idx = (int'(last_q) + 1 + i) % PORT_NUM;
            if (!found && req_valid_i[idx]) begin
                found  = 1'b1;
                winner = GW'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= GW'(PORT_NUM - 1);
            cnt_q   <= '0;
            wdone_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            wdone_q <= wdone_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_d        = last_q;
        cnt_d         = cnt_q;
        wdone_d       = '0;
        m_req_valid_o = 1'b0;
        m_wvalid_o    = 1'b0;
        m_wlast_o     = 1'b0;
        rlast_o       = 1'b0;
        req_ready_o   = '0;
        wready_o      = '0;
        rvalid_o      = '0;

        case (state_q)
            ST_IDLE: begin
                if (|req_valid_i) begin
                    grant_d = winner;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                m_req_valid_o        = 1'b1;
                req_ready_o[grant_q] = m_req_ready_i;
                if (m_req_ready_i) begin
                    cnt_d   = g_len;
                    state_d = g_write ? ST_WDATA : ST_RDATA;
                end
            end
            ST_WDATA: begin
                m_wvalid_o        = g_wvalid;
                wready_o[grant_q] = m_wready_i;
                m_wlast_o         = (cnt_q == '0);
                if (g_wvalid && m_wready_i) begin
                    if (cnt_q == '0) state_d = ST_WRESP;
                    else             cnt_d   = cnt_q - 1'b1;
                end
            end
            ST_RDATA: begin
                // The slave's rlast ends the burst. The beat counter is
                // informational here, so a length mismatch is not flagged.
                rvalid_o[grant_q] = m_rvalid_i;
                rlast_o           = m_rlast_i;
                if (m_rvalid_i) begin
                    if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
                    if (m_rlast_i) begin
                        last_d  = grant_q;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_WRESP: begin
                if (m_bvalid_i) begin
                    wdone_d[grant_q] = 1'b1;
                    last_d           = grant_q;
                    state_d          = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign m_addr_o  = g_addr;
    assign m_write_o = g_write;
    assign m_len_o   = g_len;
    assign m_wdata_o = g_wdata;
    assign rdata_o   = m_rdata_i;
    assign wdone_o   = wdone_q;
    assign fsm_state = state_q;

endmodule

// File: tb/tb_cache_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cache_port_arbiter
//   Directed bench for cache_port_arbiter. It uses three instances:
//     u_a : PORT_NUM=2, round-robin
//     u_b : PORT_NUM=4, fixed priority
//     u_c : PORT_NUM=3, round-robin
//   All three share the master-side inputs and the reset. An instance that has
//   no request pending stays in IDLE and ignores the master inputs, so each
//   scenario exercises exactly one instance.
// ---------------------------------------------------------------------------
module tb_cache_port_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int LW = 4;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ADDR  = 3'd1;
    localparam logic [2:0] S_WDATA = 3'd2;
    localparam logic [2:0] S_RDATA = 3'd3;
    localparam logic [2:0] S_WRESP = 3'd4;

    logic clk;
    logic rst_n;

    // shared master-side stimulus
    logic          m_req_ready, m_wready, m_rvalid, m_rlast, m_bvalid;
    logic [DW-1:0] m_rdata;

    // instance a (2 ports, round-robin)
    logic [1:0]    a_req_valid, a_req_ready, a_req_write, a_wvalid, a_wready, a_rvalid, a_wdone;
    logic [2*AW-1:0] a_req_addr;
    logic [2*LW-1:0] a_req_len;
    logic [2*DW-1:0] a_wdata;
    logic [DW-1:0] a_rdata, a_m_wdata;
    logic          a_rlast, a_m_req_valid, a_m_write, a_m_wvalid, a_m_wlast;
    logic [AW-1:0] a_m_addr;
    logic [LW-1:0] a_m_len;
    logic [2:0]    a_state;

    // instance b (4 ports, fixed priority)
    logic [3:0]    b_req_valid, b_req_ready, b_req_write, b_wvalid, b_wready, b_rvalid, b_wdone;
    logic [4*AW-1:0] b_req_addr;
    logic [4*LW-1:0] b_req_len;
    logic [4*DW-1:0] b_wdata;
    logic [DW-1:0] b_rdata, b_m_wdata;
    logic          b_rlast, b_m_req_valid, b_m_write, b_m_wvalid, b_m_wlast;
    logic [AW-1:0] b_m_addr;
    logic [LW-1:0] b_m_len;
    logic [2:0]    b_state;

    // instance c (3 ports, round-robin)
    logic [2:0]    c_req_valid, c_req_ready, c_req_write, c_wvalid, c_wready, c_rvalid, c_wdone;
    logic [3*AW-1:0] c_req_addr;
    logic [3*LW-1:0] c_req_len;
    logic [3*DW-1:0] c_wdata;
    logic [DW-1:0] c_rdata, c_m_wdata;
    logic          c_rlast, c_m_req_valid, c_m_write, c_m_wvalid, c_m_wlast;
    logic [AW-1:0] c_m_addr;
    logic [LW-1:0] c_m_len;
    logic [2:0]    c_state;

    int tests_run;
    int tests_failed;

    cache_port_arbiter #(.PORT_NUM(2), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .PRIO_MODE(0)) u_a (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(a_req_valid), .req_ready_o(a_req_ready), .req_addr_i(a_req_addr),
        .req_write_i(a_req_write), .req_len_i(a_req_len),
        .wdata_i(a_wdata), .wvalid_i(a_wvalid), .wready_o(a_wready),
        .rdata_o(a_rdata), .rvalid_o(a_rvalid), .rlast_o(a_rlast), .wdone_o(a_wdone),
        .m_req_valid_o(a_m_req_valid), .m_req_ready_i(m_req_ready), .m_addr_o(a_m_addr),
        .m_write_o(a_m_write), .m_len_o(a_m_len),
        .m_wdata_o(a_m_wdata), .m_wvalid_o(a_m_wvalid), .m_wready_i(m_wready), .m_wlast_o(a_m_wlast),
        .m_rdata_i(m_rdata), .m_rvalid_i(m_rvalid), .m_rlast_i(m_rlast), .m_bvalid_i(m_bvalid),
        .fsm_state(a_state)
    );

    cache_port_arbiter #(.PORT_NUM(4), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .PRIO_MODE(1)) u_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_addr_i(b_req_addr),
        .req_write_i(b_req_write), .req_len_i(b_req_len),
        .wdata_i(b_wdata), .wvalid_i(b_wvalid), .wready_o(b_wready),
        .rdata_o(b_rdata), .rvalid_o(b_rvalid), .rlast_o(b_rlast), .wdone_o(b_wdone),
        .m_req_valid_o(b_m_req_valid), .m_req_ready_i(m_req_ready), .m_addr_o(b_m_addr),
        .m_write_o(b_m_write), .m_len_o(b_m_len),
        .m_wdata_o(b_m_wdata), .m_wvalid_o(b_m_wvalid), .m_wready_i(m_wready), .m_wlast_o(b_m_wlast),
        .m_rdata_i(m_rdata), .m_rvalid_i(m_rvalid), .m_rlast_i(m_rlast), .m_bvalid_i(m_bvalid),
        .fsm_state(b_state)
    );

    cache_port_arbiter #(.PORT_NUM(3), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .PRIO_MODE(0)) u_c (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(c_req_valid), .req_ready_o(c_req_ready), .req_addr_i(c_req_addr),
        .req_write_i(c_req_write), .req_len_i(c_req_len),
        .wdata_i(c_wdata), .wvalid_i(c_wvalid), .wready_o(c_wready),
        .rdata_o(c_rdata), .rvalid_o(c_rvalid), .rlast_o(c_rlast), .wdone_o(c_wdone),
        .m_req_valid_o(c_m_req_valid), .m_req_ready_i(m_req_ready), .m_addr_o(c_m_addr),
        .m_write_o(c_m_write), .m_len_o(c_m_len),
        .m_wdata_o(c_m_wdata), .m_wvalid_o(c_m_wvalid), .m_wready_i(m_wready), .m_wlast_o(c_m_wlast),
        .m_rdata_i(m_rdata), .m_rvalid_i(m_rvalid), .m_rlast_i(m_rlast), .m_bvalid_i(m_bvalid),
        .fsm_state(c_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // driver helpers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b1;
        m_req_ready  = 1'b0; m_wready = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0; m_bvalid = 1'b0;
        m_rdata      = '0;
        a_req_valid = '0; a_req_write = '0; a_wvalid = '0; a_req_addr = '0; a_req_len = '0; a_wdata = '0;
        b_req_valid = '0; b_req_write = '0; b_wvalid = '0; b_req_addr = '0; b_req_len = '0; b_wdata = '0;
        c_req_valid = '0; c_req_write = '0; c_wvalid = '0; c_req_addr = '0; c_req_len = '0; c_wdata = '0;

        // ---------------- reset state ----------------
        #1 rst_n = 1'b0;
        #2;
        check("rst_state", 32'(a_state), 32'(S_IDLE));
        check("rst_m_req_valid", 32'(a_m_req_valid), 0);
        check("rst_req_ready", 32'(a_req_ready), 0);
        check("rst_rvalid", 32'(a_rvalid), 0);
        check("rst_wdone", 32'(a_wdone), 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // ---------------- both ports read len=3 together, port 0 first ----------------
        a_req_addr  = {16'h2000, 16'h1000};
        a_req_len   = {4'd3, 4'd3};
        a_req_write = 2'b00;
        a_req_valid = 2'b11;
        m_req_ready = 1'b1;
        #1;
        check("rr_idle_before", 32'(a_state), 32'(S_IDLE));
        tick();
        check("rr_p0_addr_state", 32'(a_state), 32'(S_ADDR));
        check("rr_p0_m_req_valid", 32'(a_m_req_valid), 1);
        check("rr_p0_m_addr", 32'(a_m_addr), 32'h1000);
        check("rr_p0_m_len", 32'(a_m_len), 3);
        check("rr_p0_req_ready", 32'(a_req_ready), 32'b01);
        tick();
        a_req_valid = 2'b10;
        check("rr_p0_rdata_state", 32'(a_state), 32'(S_RDATA));
        for (int k = 0; k < 4; k++) begin
            m_rvalid = 1'b1;
            m_rdata  = 16'hA0 + 16'(k);
            m_rlast  = (k == 3);
            #1;
            check("rr_p0_rvalid", 32'(a_rvalid), 32'b01);
            check("rr_p0_rdata", 32'(a_rdata), 32'h00A0 + 32'(k));
            check("rr_p0_rlast", 32'(a_rlast), (k == 3) ? 1 : 0);
            tick();
        end
        m_rvalid = 1'b0; m_rlast = 1'b0;
        #1;
        check("rr_gap_state", 32'(a_state), 32'(S_IDLE));
        check("rr_gap_m_req_valid", 32'(a_m_req_valid), 0);
        tick();
        check("rr_p1_m_addr", 32'(a_m_addr), 32'h2000);
        check("rr_p1_req_ready", 32'(a_req_ready), 32'b10);
        tick();
        a_req_valid = 2'b00;
        for (int k = 0; k < 4; k++) begin
            m_rvalid = 1'b1;
            m_rdata  = 16'hB0 + 16'(k);
            m_rlast  = (k == 3);
            #1;
            check("rr_p1_rvalid", 32'(a_rvalid), 32'b10);
            tick();
        end
        m_rvalid = 1'b0; m_rlast = 1'b0;
        #1;
        check("rr_end_state", 32'(a_state), 32'(S_IDLE));

        // ---------------- port 1 single-beat write with wready stall ----------------
        m_wready    = 1'b0;
        a_req_addr  = {16'h3000, 16'h0000};
        a_req_len   = {4'd0, 4'd0};
        a_req_write = 2'b10;
        a_wdata     = {16'hBEEF, 16'h0000};
        a_wvalid    = 2'b10;
        a_req_valid = 2'b10;
        tick();
        check("wr_m_write", 32'(a_m_write), 1);
        check("wr_m_addr", 32'(a_m_addr), 32'h3000);
        tick();
        a_req_valid = 2'b00;
        check("wr_wdata_state", 32'(a_state), 32'(S_WDATA));
        for (int k = 0; k < 3; k++) begin
            check("wr_stall_wvalid", 32'(a_m_wvalid), 1);
            check("wr_stall_wlast", 32'(a_m_wlast), 1);
            check("wr_stall_wready", 32'(a_wready), 0);
            check("wr_stall_state", 32'(a_state), 32'(S_WDATA));
            tick();
        end
        m_wready = 1'b1;
        #1;
        check("wr_wready_port", 32'(a_wready), 32'b10);
        check("wr_m_wdata", 32'(a_m_wdata), 32'hBEEF);
        tick();
        m_wready = 1'b0;
        a_wvalid = 2'b00;
        check("wr_wresp_state", 32'(a_state), 32'(S_WRESP));
        check("wr_wdone_wait", 32'(a_wdone), 0);
        m_bvalid = 1'b1;
        #1;
        check("wr_wdone_same_cycle", 32'(a_wdone), 0);
        tick();
        m_bvalid = 1'b0;
        check("wr_wdone_pulse", 32'(a_wdone), 32'b10);
        check("wr_back_idle", 32'(a_state), 32'(S_IDLE));
        tick();
        check("wr_wdone_cleared", 32'(a_wdone), 0);

        // ---------------- address stall for 5 cycles, then reset inside RDATA ----------------
        m_req_ready = 1'b0;
        a_req_addr  = {16'h5555, 16'h4444};
        a_req_len   = {4'd0, 4'd3};
        a_req_write = 2'b00;
        a_req_valid = 2'b01;
        tick();
        for (int k = 0; k < 5; k++) begin
            check("stall_m_addr", 32'(a_m_addr), 32'h4444);
            check("stall_req_ready", 32'(a_req_ready), 0);
            check("stall_state", 32'(a_state), 32'(S_ADDR));
            tick();
        end
        m_req_ready = 1'b1;
        #1;
        check("stall_release_ready", 32'(a_req_ready), 32'b01);
        tick();
        a_req_valid = 2'b10;
        for (int k = 0; k < 2; k++) begin
            m_rvalid = 1'b1;
            m_rdata  = 16'hC0 + 16'(k);
            tick();
        end
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_rvalid", 32'(a_rvalid), 0);
        check("rst_mid_state", 32'(a_state), 32'(S_IDLE));
        check("rst_mid_rlast", 32'(a_rlast), 0);
        m_rvalid = 1'b0;
        #1 rst_n = 1'b1;
        tick();
        check("rst_rearb_m_req_valid", 32'(a_m_req_valid), 1);
        check("rst_rearb_m_addr", 32'(a_m_addr), 32'h5555);
        check("rst_rearb_req_ready", 32'(a_req_ready), 32'b10);
        check("rst_rearb_wdone", 32'(a_wdone), 0);
        tick();
        a_req_valid = 2'b00;
        m_rvalid = 1'b1; m_rlast = 1'b1;
        #1;
        check("rst_rearb_rvalid", 32'(a_rvalid), 32'b10);
        tick();
        m_rvalid = 1'b0; m_rlast = 1'b0;
        #1;
        check("rst_rearb_done", 32'(a_state), 32'(S_IDLE));

        // ---------------- fixed priority, port 0 keeps requesting ----------------
        b_req_addr  = {16'hD003, 16'hD002, 16'hD001, 16'hD000};
        b_req_len   = '0;
        b_req_valid = 4'b1001;
        m_req_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("prio_m_addr", 32'(b_m_addr), 32'hD000);
            check("prio_req_ready", 32'(b_req_ready), 32'b0001);
            tick();
            m_rvalid = 1'b1; m_rlast = 1'b1;
            #1;
            check("prio_rvalid", 32'(b_rvalid), 32'b0001);
            tick();
            m_rvalid = 1'b0; m_rlast = 1'b0;
        end
        b_req_valid = 4'b1000;
        tick();
        check("prio_p3_m_addr", 32'(b_m_addr), 32'hD003);
        check("prio_p3_req_ready", 32'(b_req_ready), 32'b1000);
        tick();
        b_req_valid = 4'b0000;
        m_rvalid = 1'b1; m_rlast = 1'b1;
        #1;
        check("prio_p3_rvalid", 32'(b_rvalid), 32'b1000);
        tick();
        m_rvalid = 1'b0; m_rlast = 1'b0;

        // ---------------- round-robin wrap on 3 ports ----------------
        c_req_addr  = {16'h0300, 16'h0200, 16'h0100};
        c_req_len   = '0;
        c_req_valid = 3'b111;
        for (int k = 0; k < 4; k++) begin
            logic [1:0] exp_port;
            exp_port = (k == 3) ? 2'd0 : 2'(k);
            tick();
            check("wrap_m_addr", 32'(c_m_addr), 32'h0100 * (32'(exp_port) + 1));
            check("wrap_req_ready", 32'(c_req_ready), 32'(3'b001 << exp_port));
            tick();
            m_rvalid = 1'b1; m_rlast = 1'b1;
            #1;
            check("wrap_rvalid", 32'(c_rvalid), 32'(3'b001 << exp_port));
            tick();
            m_rvalid = 1'b0; m_rlast = 1'b0;
        end
        c_req_valid = 3'b000;
        tick();
        check("wrap_end_state", 32'(c_state), 32'(S_IDLE));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/cache_port_arbiter.md
CACHE_PORT_ARBITER -- requirements
Module: cache_port_arbiter

Interface
REQ-001 SHALL have parameter PORT_NUM, default 2; number of cache request ports (1..8).
REQ-002 SHALL have parameter ADDR_W, default 32; address width.
REQ-003 SHALL have parameter DATA_W, default 32; data beat width.
REQ-004 SHALL have parameter LEN_W, default 8; burst length field width (beats minus 1).
REQ-005 SHALL have parameter PRIO_MODE, default 0; 0 = round-robin, 1 = fixed priority (lowest index wins).
REQ-006 SHALL have clk  input  1  sole clock; all state on rising edge.
REQ-007 SHALL have rst_n  input  1  asynchronous, active-low reset.
REQ-008 SHALL have req_valid_i / req_ready_o  in/out  PORT_NUM  per-port request handshake.
REQ-009 SHALL have req_addr_i  input  PORT_NUM*ADDR_W  per-port start address.
REQ-010 SHALL have req_write_i  input  PORT_NUM  per-port, 1 = write burst.
REQ-011 SHALL have req_len_i  input  PORT_NUM*LEN_W  per-port beats minus 1.
REQ-012 SHALL have wdata_i  input  PORT_NUM*DATA_W, wvalid_i  input  PORT_NUM, wready_o  output  PORT_NUM; per-port write data handshake.
REQ-013 SHALL have rdata_o  output  DATA_W (shared), rvalid_o  output  PORT_NUM, rlast_o  output  1, wdone_o  output  PORT_NUM.
REQ-014 SHALL have m_req_valid_o  output  1, m_req_ready_i  input  1, m_addr_o  output  ADDR_W, m_write_o  output  1, m_len_o  output  LEN_W.
REQ-015 SHALL have m_wdata_o  output  DATA_W, m_wvalid_o  output  1, m_wready_i  input  1, m_wlast_o  output  1.
REQ-016 SHALL have m_rdata_i  input  DATA_W, m_rvalid_i  input  1, m_rlast_i  input  1, m_bvalid_i  input  1 (write response).

Function
REQ-017 SHALL implement FSM states IDLE, ADDR, WDATA, RDATA, WRESP; one transaction outstanding.
REQ-018 IDLE: if any req_valid_i, SHALL select winner combinationally per PRIO_MODE, register grant index, go to ADDR next cycle.
REQ-019 Round-robin SHALL search from (last_served+1) mod PORT_NUM upward with wrap; last_served updates only on transaction completion.
REQ-020 ADDR: m_req_valid_o=1 with granted port's addr/write/len; req_ready_o[grant] SHALL equal m_req_ready_i; on handshake go to WDATA (write) or RDATA (read) and latch len into beat counter.
REQ-021 Granted port's request fields SHALL stay stable while m_req_valid_o=1; address is not latched.
REQ-022 WDATA: m_wvalid_o = wvalid_i[grant], wready_o[grant] = m_wready_i, others 0; counter decrements per beat; m_wlast_o=1 when counter==0; last beat -> WRESP.
REQ-023 WRESP: on m_bvalid_i pulse wdone_o[grant] for one cycle, return to IDLE.
REQ-024 RDATA: rvalid_o[grant]=m_rvalid_i, rdata_o=m_rdata_i, rlast_o=m_rlast_i; on m_rvalid_i&&m_rlast_i return to IDLE; counter mismatch ignored.
REQ-025 Grant SHALL remain locked ADDR through completion; new req_valid_i on other ports SHALL not preempt.
REQ-026 Return to IDLE and new grant SHALL cost one idle cycle (completion cycle N, next m_req_valid_o earliest N+2).
REQ-027 req_len_i=0 SHALL produce single-beat burst (m_wlast_o on first beat).
REQ-028 PORT_NUM=1 SHALL degenerate to pass-through with same FSM timing.
REQ-029 Non-granted ports SHALL see req_ready_o, wready_o, rvalid_o, wdone_o all 0.

Reset
REQ-030 On rst_n low SHALL immediately force IDLE, grant 0, last_served PORT_NUM-1, counter 0, all valid/ready/done outputs 0.
REQ-031 Reset mid-burst SHALL abandon the transaction; no completion pulse after release.

Verification
REQ-032 PORT_NUM=2, RR, both ports read len=3 in same cycle after reset -> port 0 served first (4 rvalid_o[0]), then port 1; rvalid_o[1] never during port 0 burst.
REQ-033 PRIO_MODE=1, PORT_NUM=4, port 0 re-requests continuously, port 3 pending -> port 3 never granted while port 0 valid.
REQ-034 Write len=0 from port 1, m_wready_i held 0 for 3 cycles -> m_wlast_o=1 on first beat, wdone_o[1] pulses one cycle after m_bvalid_i.
REQ-035 RR, PORT_NUM=3, all ports valid -> grant order 0,1,2,0 (wrap verified).
REQ-036 rst_n asserted in RDATA after 2 beats -> outputs 0 same cycle; after release, pending request re-arbitrated from IDLE.
REQ-037 m_req_ready_i low 5 cycles in ADDR -> m_addr_o stable, req_ready_o low, no state change.
